// File: rtl/wait_timer_pkg.sv
// Shared definitions for the wait_timer block: state encoding, default
// parameter values and the prescaler width helper.
package wait_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int WT_WIDTH_DEF    = 8;
    localparam int WT_PRESCALE_DEF = 1;

    // ceil(log2(presc)), never narrower than one bit
    function automatic int presc_width(input int presc);
        return (presc > 1) ? $clog2(presc) : 1;
    endfunction

endpackage

// File: rtl/wait_prescaler.sv
// Prescaler for wait_timer: counts 0..PRESCALE-1 while enabled and flags the
// last count with tick, which is the cycle the unit counter advances.
module wait_prescaler
    import wait_timer_pkg::*;
#(
    parameter int PRESCALE = WT_PRESCALE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int             PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

    generate
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_cfg_err
            $error("wait_prescaler: PRESCALE must be in 1..65535");
        end
    endgenerate

    logic [PW-1:0] r_cnt;

    // With PRESCALE=1 every cycle is a unit boundary.
    assign tick = (PRESCALE == 1) ? 1'b1 : (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wait_timer.sv
// Programmable delay timer: start loads din units of PRESCALE cycles each.
// Optional macro WAIT_TIMER_RETRIGGER_EN lets a non-zero start reload a running delay.
module wait_timer
    import wait_timer_pkg::*;
#(
    parameter int WIDTH    = WT_WIDTH_DEF,
    parameter int PRESCALE = WT_PRESCALE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remain
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           r_state;
    logic [WIDTH-1:0] r_remain;
    logic             r_done;

    logic w_tick;
    logic w_din_zero;
    logic w_retrig;
    logic w_clear;

    assign w_din_zero = (din == '0);

`ifdef WAIT_TIMER_RETRIGGER_EN
    assign w_retrig = (r_state == RUN) && start && !abort && !w_din_zero;
`else
    assign w_retrig = 1'b0;
`endif

    // Prescaler restarts from zero on every fresh load, abort or idle cycle.
    assign w_clear = (r_state == IDLE) || abort || w_retrig;

    wait_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .enable (r_state == RUN),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_remain <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        if (w_din_zero) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state  <= RUN;
                            r_remain <= din;
                        end
                    end
                end
                RUN: begin
                    // Priority: abort, then completion, then reload, then countdown.
                    if (abort) begin
                        r_state  <= IDLE;
                        r_remain <= '0;
                    end else if (w_tick && r_remain == ONE) begin
                        r_state  <= IDLE;
                        r_remain <= '0;
                        r_done   <= 1'b1;
                    end else if (w_retrig) begin
                        r_remain <= din;
                    end else if (w_tick) begin
                        r_remain <= r_remain - ONE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_remain <= '0;
                end
            endcase
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = r_done;
    assign remain = r_remain;

endmodule

// File: tb/tb_wait_timer.sv
// Bench for wait_timer (WIDTH=8, PRESCALE=4): directed scenarios plus random
// traffic, checked against a start-time/elapsed-cycles reference model.
module tb_wait_timer;

    localparam int W = 8;
    localparam int P = 4;
`ifdef WAIT_TIMER_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic [W-1:0] din   = '0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] remain;

    always #5 clk = ~clk;

    wait_timer #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .start  (start),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .remain (remain)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int e      = 0;    // edges seen since time zero
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_s    = 0;    // edge at which the current delay was loaded
    int m_n    = 0;    // units loaded at m_s
    int busy_cnt, done_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Busy spans edges m_s .. m_s+N*P-1; remain drops one per P elapsed cycles.
    task automatic model_edge();
        int d;
        d      = e - m_s;
        m_done = 1'b0;
        if (m_run) begin
            if (abort) m_run = 1'b0;
            else if (d == m_n * P) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else if (RETRIG && start && din != 0) begin
                m_s = e;
                m_n = int'(din);
            end
        end else if (start && !abort) begin
            if (din == 0) m_done = 1'b1;
            else begin
                m_run = 1'b1;
                m_s   = e;
                m_n   = int'(din);
            end
        end
    endtask

    task automatic step();
        int exp_rem;
        @(posedge clk);
        e++;
        model_edge();
        #1;
        exp_rem = m_run ? (m_n - (e - m_s) / P) : 0;
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("remain", 32'(remain), 32'(exp_rem));
        busy_cnt += int'(busy);
        done_cnt += int'(done);
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic pulse_start(input int n);
        din   = W'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clr_cnt();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    // Called just after a sampling point, so the reset lands mid-cycle.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        m_run  = 1'b0;
        m_done = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_remain", 32'(remain), 32'd0);
        #3 rst = 1'b1;
    endtask

    initial begin
        clr_cnt();
        #1;
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_remain", 32'(remain), 32'd0);
        #12 rst = 1'b1;

        // basic run, accepted on the first edge after reset release
        clr_cnt();
        pulse_start(3);
        run(14);
        chk("basic_busy_len", 32'(busy_cnt), 32'd12);
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);

        // zero length
        clr_cnt();
        pulse_start(0);
        run(3);
        chk("zero_busy_len", 32'(busy_cnt), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);

        // abort six cycles after start
        clr_cnt();
        pulse_start(5);
        run(5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_remain", 32'(remain), 32'd0);
        run(25);
        chk("abort_busy_len", 32'(busy_cnt), 32'd6);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);

        // start while running
        clr_cnt();
        pulse_start(3);
        run(5);
        pulse_start(2);
        run(20);
        chk("retrig_busy_len", 32'(busy_cnt), RETRIG ? 32'd14 : 32'd12);
        chk("retrig_done_cnt", 32'(done_cnt), 32'd1);

        // abort in idle, and abort beating start
        clr_cnt();
        abort = 1'b1;
        din   = 8'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        abort = 1'b0;
        run(2);
        chk("idle_abort_busy", 32'(busy_cnt), 32'd0);
        chk("idle_abort_done", 32'(done_cnt), 32'd0);

        // start on the completion edge is ignored
        clr_cnt();
        pulse_start(2);
        run(7);
        pulse_start(5);
        run(3);
        chk("cmpl_start_busy", 32'(busy_cnt), 32'd8);
        chk("cmpl_start_done", 32'(done_cnt), 32'd1);

        // reset while remain=2, then a one-unit run
        pulse_start(3);
        run(4);
        chk("pre_rst_remain", 32'(remain), 32'd2);
        do_reset();
        clr_cnt();
        pulse_start(1);
        run(6);
        chk("post_rst_busy", 32'(busy_cnt), 32'd4);
        chk("post_rst_done", 32'(done_cnt), 32'd1);

        // maximum count
        clr_cnt();
        pulse_start(255);
        run(1025);
        chk("max_busy_len", 32'(busy_cnt), 32'd1020);
        chk("max_done_cnt", 32'(done_cnt), 32'd1);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 39) == 0);
            din   = ($urandom_range(0, 19) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            step();
            start = 1'b0;
            abort = 1'b0;
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
